// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP video back-end: scanline mode encodings,
// sync-measurement counter widths and the channel dimming helper.
package vdp_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_75  = 2'b01;
  localparam logic [1:0] MODE_50  = 2'b10;
  localparam logic [1:0] MODE_25  = 2'b11;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  // Every result is <= c, so 4-bit arithmetic never wraps and black stays black.
  function automatic logic [3:0] scan_dim(input logic [3:0] c, input logic [1:0] mode);
    case (mode)
      MODE_75: scan_dim = c - (c >> 2);
      MODE_50: scan_dim = c >> 1;
      MODE_25: scan_dim = c >> 2;
      default: scan_dim = c;
    endcase
  endfunction

endpackage

// File: rtl/vga_scanfx_if.sv
// Pixel/sync bundle between the VDP colormap stage and the scanline effect.
interface vga_scanfx_if;

  logic       hsync_i;
  logic       vsync_i;
  logic [3:0] r_i;
  logic [3:0] g_i;
  logic [3:0] b_i;
  logic [1:0] mode_i;
  logic       hsync_o;
  logic       vsync_o;
  logic [3:0] r_o;
  logic [3:0] g_o;
  logic [3:0] b_o;
  logic       hpol_o;
  logic       vpol_o;

  modport master (
    output hsync_i, vsync_i, r_i, g_i, b_i, mode_i,
    input  hsync_o, vsync_o, r_o, g_o, b_o, hpol_o, vpol_o
  );

  modport slave (
    input  hsync_i, vsync_i, r_i, g_i, b_i, mode_i,
    output hsync_o, vsync_o, r_o, g_o, b_o, hpol_o, vpol_o
  );

endinterface

// File: rtl/vga_syncpol.sv
// Sync polarity detector: measures high vs low time between rising edges and
// reports the shorter level as active, plus a strobe on entry into that level.
module vga_syncpol #(
  parameter int W = 11
) (
  input  logic clk40m,
  input  logic rst,
  input  logic cnt_en,
  input  logic sync,
  output logic pol,
  output logic act
);

  logic         sync_q;
  logic         armed;
  logic [W-1:0] hi_cnt;
  logic [W-1:0] lo_cnt;
  logic         rise;

  assign rise = sync & ~sync_q;
  assign act  = (sync == pol) && (sync_q != pol);

  // sync_q tracks the live input during reset so a level already present when
  // reset drops is not mistaken for an edge; the first real edge only arms.
  always_ff @(posedge clk40m) begin
    if (rst) begin
      sync_q <= sync;
      armed  <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
      pol    <= 1'b1;
    end else begin
      sync_q <= sync;
      if (rise) begin
        if (armed && (hi_cnt != lo_cnt)) begin
          pol <= (hi_cnt < lo_cnt);
        end
        hi_cnt <= '0;
        lo_cnt <= '0;
        armed  <= 1'b1;
      end else if (cnt_en) begin
        if (sync) begin
          if (hi_cnt != {W{1'b1}}) hi_cnt <= hi_cnt + 1'b1;
        end else begin
          if (lo_cnt != {W{1'b1}}) lo_cnt <= lo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_scanfx.sv
// Scanline darkening effect: dims every other line by the frame-latched mode,
// with sync polarity auto-detection and a fixed two-stage pipeline.
module vga_scanfx (
  input logic         clk40m,
  input logic         rst,
  vga_scanfx_if.slave vif
);

  import vdp_pkg::*;

  logic       hpol;
  logic       vpol;
  logic       h_act;
  logic       v_act;
  logic       parity;
  logic [1:0] mode_lat;
  pix_t       s1_next;
  pix_t       s1;
  pix_t       s2;

  vga_syncpol #(.W(HCNT_W)) u_hsync_pol (
    .clk40m (clk40m),
    .rst    (rst),
    .cnt_en (1'b1),
    .sync   (vif.hsync_i),
    .pol    (hpol),
    .act    (h_act)
  );

  // Frame measurement counts lines, so it only advances on hsync active edges.
  vga_syncpol #(.W(VCNT_W)) u_vsync_pol (
    .clk40m (clk40m),
    .rst    (rst),
    .cnt_en (h_act),
    .sync   (vif.vsync_i),
    .pol    (vpol),
    .act    (v_act)
  );

  always_comb begin
    s1_next.hsync = vif.hsync_i;
    s1_next.vsync = vif.vsync_i;
    s1_next.r     = parity ? scan_dim(vif.r_i, mode_lat) : vif.r_i;
    s1_next.g     = parity ? scan_dim(vif.g_i, mode_lat) : vif.g_i;
    s1_next.b     = parity ? scan_dim(vif.b_i, mode_lat) : vif.b_i;
  end

  // A frame start clears parity even when it coincides with a line start.
  always_ff @(posedge clk40m) begin
    if (rst) begin
      parity   <= 1'b0;
      mode_lat <= MODE_OFF;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (v_act) begin
        parity   <= 1'b0;
        mode_lat <= vif.mode_i;
      end else if (h_act) begin
        parity <= ~parity;
      end
      s1 <= s1_next;
      s2 <= s1;
    end
  end

  assign vif.hsync_o = s2.hsync;
  assign vif.vsync_o = s2.vsync;
  assign vif.r_o     = s2.r;
  assign vif.g_o     = s2.g;
  assign vif.b_o     = s2.b;
  assign vif.hpol_o  = hpol;
  assign vif.vpol_o  = vpol;

endmodule

// File: tb/tb_vga_scanfx.sv
// Bench for vga_scanfx: a per-cycle reference model plus directed frame and
// line sequences with hand-computed pixel and polarity expectations.
module tb_vga_scanfx;

  logic clk40m = 1'b0;
  logic rst;
  logic inv;
  int   checks = 0;
  int   errors = 0;

  vga_scanfx_if vif ();

  vga_scanfx dut (
    .clk40m (clk40m),
    .rst    (rst),
    .vif    (vif)
  );

  always #5 clk40m = ~clk40m;

  // Reference state: polarities, frame-relative line parity, latched mode,
  // the samples seen since the last sync rise and the two expected stages.
  logic        m_valid = 1'b0;
  logic        m_hpol, m_vpol, m_hs_prev, m_vs_prev, m_par, m_h_seen, m_v_seen;
  logic [1:0]  m_mode;
  logic [13:0] m_s1, m_s2;
  logic        h_hist[$];
  logic        v_hist[$];

  function automatic logic [3:0] model_dim(input int c, input logic [1:0] m);
    case (m)
      2'd1:    return 4'(c - c / 4);
      2'd2:    return 4'(c / 2);
      2'd3:    return 4'(c / 4);
      default: return 4'(c);
    endcase
  endfunction

  task automatic model_step();
    logic h_act, v_act, h_rise, v_rise;
    int   hi, lo;
    logic [3:0] r, g, b;
    if (rst) begin
      m_valid = 1'b1;
      m_hpol = 1'b1; m_vpol = 1'b1; m_par = 1'b0; m_mode = 2'b00;
      m_h_seen = 1'b0; m_v_seen = 1'b0;
      m_hs_prev = vif.hsync_i; m_vs_prev = vif.vsync_i;
      m_s1 = '0; m_s2 = '0;
      h_hist.delete(); v_hist.delete();
    end else begin
      h_act  = (vif.hsync_i == m_hpol) && (m_hs_prev != m_hpol);
      v_act  = (vif.vsync_i == m_vpol) && (m_vs_prev != m_vpol);
      h_rise = vif.hsync_i && !m_hs_prev;
      v_rise = vif.vsync_i && !m_vs_prev;
      r = vif.r_i; g = vif.g_i; b = vif.b_i;
      if (m_par) begin
        r = model_dim(int'(vif.r_i), m_mode);
        g = model_dim(int'(vif.g_i), m_mode);
        b = model_dim(int'(vif.b_i), m_mode);
      end
      m_s2 = m_s1;
      m_s1 = {vif.hsync_i, vif.vsync_i, r, g, b};
      if (h_rise) begin
        hi = 0; lo = 0;
        foreach (h_hist[i]) if (h_hist[i]) hi++; else lo++;
        if (hi > 2047) hi = 2047;
        if (lo > 2047) lo = 2047;
        if (m_h_seen && hi < lo) m_hpol = 1'b1;
        else if (m_h_seen && hi > lo) m_hpol = 1'b0;
        h_hist.delete();
        m_h_seen = 1'b1;
      end else begin
        h_hist.push_back(vif.hsync_i);
      end
      if (v_rise) begin
        hi = 0; lo = 0;
        foreach (v_hist[i]) if (v_hist[i]) hi++; else lo++;
        if (hi > 1023) hi = 1023;
        if (lo > 1023) lo = 1023;
        if (m_v_seen && hi < lo) m_vpol = 1'b1;
        else if (m_v_seen && hi > lo) m_vpol = 1'b0;
        v_hist.delete();
        m_v_seen = 1'b1;
      end else if (h_act) begin
        v_hist.push_back(vif.vsync_i);
      end
      if (v_act) begin
        m_par  = 1'b0;
        m_mode = vif.mode_i;
      end else if (h_act) begin
        m_par = ~m_par;
      end
      m_hs_prev = vif.hsync_i;
      m_vs_prev = vif.vsync_i;
    end
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk40m);
    model_step();
  end

  initial forever begin
    @(negedge clk40m);
    if (m_valid)
      check_output("cycle_cmp",
                   {vif.hsync_o, vif.vsync_o, vif.r_o, vif.g_o, vif.b_o, vif.hpol_o, vif.vpol_o},
                   {m_s2, m_hpol, m_vpol});
  end

  // One line: hsync pulse then blanking; optional literal colour check at a
  // mid-line point whose output pixel came from the same line.
  task automatic apply_stimulus(input int hi_len, input int lo_len, input logic v_lvl,
                                input logic chk, input logic [11:0] exp_rgb);
    for (int j = 0; j < hi_len + lo_len; j++) begin
      @(negedge clk40m);
      if (chk && j == 20) check_output("line_rgb", {4'h0, vif.r_o, vif.g_o, vif.b_o}, {4'h0, exp_rgb});
      vif.hsync_i = (j < hi_len) ^ inv;
      vif.vsync_i = v_lvl ^ inv;
    end
  endtask

  task automatic apply_frame(input int hi_len, input int lo_len, input int vhi, input int vlo,
                             input logic chk, input logic [11:0] exp_even, input logic [11:0] exp_odd,
                             input logic [1:0] mode_start, input logic [1:0] mode_mid);
    vif.mode_i = mode_start;
    for (int l = 0; l < vhi + vlo; l++) begin
      if (l == 2) vif.mode_i = mode_mid;
      apply_stimulus(hi_len, lo_len, l < vhi, chk && l < 4, (l % 2 == 0) ? exp_even : exp_odd);
    end
  endtask

  task automatic do_reset(input int cycles);
    vif.hsync_i = 1'b0; vif.vsync_i = 1'b0; vif.mode_i = 2'b00;
    rst = 1'b1;
    repeat (cycles) @(negedge clk40m);
    rst = 1'b0;
  endtask

  initial begin
    inv = 1'b0;
    vif.r_i = 4'h0; vif.g_i = 4'h0; vif.b_i = 4'h0;
    do_reset(2);
    check_output("reset_out",
                 {vif.hsync_o, vif.vsync_o, vif.r_o, vif.g_o, vif.b_o, vif.hpol_o, vif.vpol_o}, 16'h0003);

    // 800x600 line timing, shortened frames (4 sync lines, 6 others).
    vif.r_i = 4'hF; vif.g_i = 4'h8; vif.b_i = 4'h1;
    repeat (2) apply_frame(128, 928, 4, 6, 1'b0, 12'h0, 12'h0, 2'b00, 2'b00);
    check_output("pol_positive", {14'h0, vif.hpol_o, vif.vpol_o}, 16'h0003);

    inv = 1'b1;
    apply_frame(128, 928, 4, 6, 1'b0, 12'h0, 12'h0, 2'b00, 2'b00);
    check_output("pol_inv_frame1", {14'h0, vif.hpol_o, vif.vpol_o}, 16'h0001);
    apply_frame(128, 928, 4, 6, 1'b0, 12'h0, 12'h0, 2'b00, 2'b00);
    check_output("pol_inv_frame2", {14'h0, vif.hpol_o, vif.vpol_o}, 16'h0000);

    // One-cycle reset in the middle of an inverted line.
    apply_stimulus(128, 472, 1'b0, 1'b0, 12'h0);
    @(negedge clk40m);
    rst = 1'b1;
    @(negedge clk40m);
    rst = 1'b0;
    check_output("midline_reset",
                 {vif.hsync_o, vif.vsync_o, vif.r_o, vif.g_o, vif.b_o, vif.hpol_o, vif.vpol_o}, 16'h0003);
    apply_stimulus(0, 456, 1'b0, 1'b0, 12'h0);
    apply_stimulus(128, 928, 1'b0, 1'b0, 12'h0);
    check_output("hpol_first_period", {15'h0, vif.hpol_o}, 16'h0001);
    apply_stimulus(128, 928, 1'b0, 1'b0, 12'h0);
    check_output("hpol_second_period", {15'h0, vif.hpol_o}, 16'h0000);

    // Short frames (8/24 lines, 2+3 lines) for the pixel path.
    inv = 1'b0;
    do_reset(2);
    vif.r_i = 4'hF; vif.g_i = 4'h8; vif.b_i = 4'h1;
    apply_frame(8, 24, 2, 3, 1'b1, 12'hF81, 12'h740, 2'b10, 2'b10);
    apply_frame(8, 24, 2, 3, 1'b1, 12'hF81, 12'hF81, 2'b00, 2'b11);
    apply_frame(8, 24, 2, 3, 1'b1, 12'hF81, 12'h320, 2'b11, 2'b11);
    apply_frame(8, 24, 2, 3, 1'b1, 12'hF81, 12'hC61, 2'b01, 2'b01);
    vif.r_i = 4'h0; vif.g_i = 4'h0; vif.b_i = 4'h0;
    apply_frame(8, 24, 2, 3, 1'b1, 12'h000, 12'h000, 2'b11, 2'b11);

    @(negedge clk40m);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
